// File: rtl/ac_burst_fire_ctrl_pkg.sv
// ac_ctrl_pkg: shared FSM state types, maximal-length LFSR tap table and parameter range check for ac_burst_fire_ctrl
package ac_ctrl_pkg;
  typedef enum logic [1:0] {SYNC_WAIT, POS, NEG} gstate_e;
  typedef enum logic [1:0] {IDLE, FIRE_POS, FIRE_NEG} cstate_e;
  function automatic logic [15:0] lfsr_taps(input int pw);
    case (pw)
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction
  function automatic bit params_ok(input int nch, input int pw, input int cw, input int zc);
    return nch >= 1 && nch <= 8 && pw >= 4 && pw <= 16 && cw >= 1 && zc >= 1;
  endfunction
endpackage

// File: rtl/ac_burst_fire_ctrl_if.sv
// ac_burst_fire_ctrl_if: control bus; master drives EN/SEED/SEED_LOAD/UI/ZC_IN/CLR_STATS, slave drives HALF_POL/ZC_PULSE/PRNG/GATE/COUNT_ZERO/COUNT_FIRE
interface ac_burst_fire_ctrl_if #(
  parameter int NCH = 4,
  parameter int PW = 8,
  parameter int CW = 21
);
  logic EN;
  logic [PW-1:0] SEED;
  logic SEED_LOAD;
  logic [NCH*PW-1:0] UI;
  logic ZC_IN;
  logic CLR_STATS;
  logic HALF_POL;
  logic ZC_PULSE;
  logic [PW-1:0] PRNG;
  logic [NCH-1:0] GATE;
  logic [CW-1:0] COUNT_ZERO;
  logic [NCH*CW-1:0] COUNT_FIRE;
  modport master (
    output EN, SEED, SEED_LOAD, UI, ZC_IN, CLR_STATS,
    input HALF_POL, ZC_PULSE, PRNG, GATE, COUNT_ZERO, COUNT_FIRE
  );
  modport slave (
    input EN, SEED, SEED_LOAD, UI, ZC_IN, CLR_STATS,
    output HALF_POL, ZC_PULSE, PRNG, GATE, COUNT_ZERO, COUNT_FIRE
  );
endinterface

// File: rtl/ac_burst_fire_ctrl_zc_filter.sv
// zc_filter: synchronises raw zero-cross level zc_in, accepts a change after ZC_FILT stable cycles (half_pol) and strobes zc_pulse the cycle after
module zc_filter #(
  parameter int ZC_FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic zc_in,
  output logic half_pol,
  output logic zc_pulse
);
  localparam int FW = $clog2(ZC_FILT + 1);
  logic [1:0] sync_q, sync_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic pol_q, pol_d, prev_q, prev_d, pulse_q, pulse_d, diff, hit;
  always_comb begin
    sync_d = {sync_q[0], zc_in};
    diff = sync_q[1] ^ pol_q;
    hit = diff && cnt_q == FW'(ZC_FILT - 1);
    cnt_d = (diff && !hit) ? cnt_q + 1'b1 : '0;
    pol_d = hit ? sync_q[1] : pol_q;
    prev_d = pol_q;
    pulse_d = pol_q ^ prev_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      pol_q <= 1'b0;
      prev_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      pol_q <= pol_d;
      prev_q <= prev_d;
      pulse_q <= pulse_d;
    end
  end
  assign half_pol = pol_q;
  assign zc_pulse = pulse_q;
endmodule

// File: rtl/ac_burst_fire_ctrl.sv
// ac_burst_fire_ctrl: NCH-channel full-cycle burst-fire triac controller; SYS_CLK, A_RESET_N and the slave side of ac_burst_fire_ctrl_if
module ac_burst_fire_ctrl
  import ac_ctrl_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW = 8,
  parameter int CW = 21,
  parameter int ZC_FILT = 3
) (
  input logic SYS_CLK,
  input logic A_RESET_N,
  ac_burst_fire_ctrl_if.slave bus
);
  localparam logic [1:0] G_SYNC_WAIT = SYNC_WAIT;
  localparam logic [1:0] G_POS = POS;
  localparam logic [1:0] G_NEG = NEG;
  localparam logic [1:0] C_IDLE = IDLE;
  localparam logic [1:0] C_FIRE_POS = FIRE_POS;
  localparam logic [1:0] C_FIRE_NEG = FIRE_NEG;
  localparam logic [PW-1:0] TAPS = PW'(lfsr_taps(PW));
  if (!params_ok(NCH, PW, CW, ZC_FILT)) begin : g_bad_params
    $error("ac_burst_fire_ctrl: parameter out of range");
  end
  logic half_pol, zc_pulse, rise, fall;
  logic [1:0] gst_q, gst_d;
  logic [PW-1:0] prng_q, prng_d;
  logic [CW-1:0] cz_q, cz_d;
  logic [NCH-1:0] gate_all;
  logic [NCH*CW-1:0] cf_all;
  zc_filter #(.ZC_FILT(ZC_FILT)) u_zc_filter (
    .clk(SYS_CLK),
    .rst_n(A_RESET_N),
    .zc_in(bus.ZC_IN),
    .half_pol(half_pol),
    .zc_pulse(zc_pulse)
  );
  // edges alternate, so the new half polarity alone names the next global state
  always_comb begin
    gst_d = zc_pulse ? (half_pol ? G_POS : G_NEG) : gst_q;
    rise = zc_pulse && half_pol && gst_q != G_SYNC_WAIT;
    fall = zc_pulse && !half_pol && gst_q != G_SYNC_WAIT;
    prng_d = bus.SEED_LOAD ? (bus.SEED == '0 ? PW'(1) : bus.SEED)
           : zc_pulse ? {prng_q[PW-2:0], ^(prng_q & TAPS)} : prng_q;
    cz_d = bus.CLR_STATS ? '0 : (zc_pulse && cz_q != '1) ? cz_q + 1'b1 : cz_q;
  end
  always_ff @(posedge SYS_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      gst_q <= G_SYNC_WAIT;
      prng_q <= PW'(1);
      cz_q <= '0;
    end else begin
      gst_q <= gst_d;
      prng_q <= prng_d;
      cz_q <= cz_d;
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int R = i % PW;
    logic [PW-1:0] view, ui;
    logic [1:0] st_q, st_d;
    logic [CW-1:0] cf_q, cf_d;
    logic gate_q, gate_d, go;
    // view is the PRNG rotated left by R; the decision uses the pre-advance PRNG
    always_comb begin
      view = PW'({prng_q, prng_q} >> (PW - R));
      ui = bus.UI[i*PW +: PW];
      go = rise && bus.EN && ui >= view && st_q != C_FIRE_POS;
      st_d = go ? C_FIRE_POS
           : (rise && st_q == C_FIRE_NEG) ? C_IDLE
           : (fall && st_q == C_FIRE_POS) ? C_FIRE_NEG : st_q;
      gate_d = st_d != C_IDLE;
      cf_d = bus.CLR_STATS ? '0 : (go && cf_q != '1) ? cf_q + 1'b1 : cf_q;
    end
    always_ff @(posedge SYS_CLK or negedge A_RESET_N) begin
      if (!A_RESET_N) begin
        st_q <= C_IDLE;
        gate_q <= 1'b0;
        cf_q <= '0;
      end else begin
        st_q <= st_d;
        gate_q <= gate_d;
        cf_q <= cf_d;
      end
    end
    assign gate_all[i] = gate_q;
    assign cf_all[i*CW +: CW] = cf_q;
  end
  assign bus.HALF_POL = half_pol;
  assign bus.ZC_PULSE = zc_pulse;
  assign bus.PRNG = prng_q;
  assign bus.GATE = gate_all;
  assign bus.COUNT_ZERO = cz_q;
  assign bus.COUNT_FIRE = cf_all;
endmodule

// File: tb/tb_ac_burst_fire_ctrl.sv
// tb_ac_burst_fire_ctrl: randomized self-checking bench for ac_burst_fire_ctrl against a per-edge behavioural model
module tb_ac_burst_fire_ctrl;
  localparam int NCH = 4;
  localparam int PW = 8;
  localparam int CW = 21;
  localparam int ZF = 3;
  localparam logic [PW-1:0] POLY = 8'hB8;
  localparam longint CFMAX = (64'd1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  bit m_sync;
  int m_st [NCH];
  logic [PW-1:0] m_prng;
  longint m_cz, m_cz4;
  longint m_cf [NCH];
  logic [PW-1:0] old_prng;
  always #5 clk = ~clk;
  ac_burst_fire_ctrl_if #(.NCH(NCH), .PW(PW), .CW(CW)) bus ();
  ac_burst_fire_ctrl_if #(.NCH(NCH), .PW(PW), .CW(4)) bus4 ();
  assign bus4.EN = bus.EN;
  assign bus4.SEED = bus.SEED;
  assign bus4.SEED_LOAD = bus.SEED_LOAD;
  assign bus4.UI = bus.UI;
  assign bus4.ZC_IN = bus.ZC_IN;
  assign bus4.CLR_STATS = bus.CLR_STATS;
  ac_burst_fire_ctrl #(.NCH(NCH), .PW(PW), .CW(CW), .ZC_FILT(ZF)) dut (
    .SYS_CLK(clk), .A_RESET_N(rst_n), .bus(bus));
  ac_burst_fire_ctrl #(.NCH(NCH), .PW(PW), .CW(4), .ZC_FILT(ZF)) dut4 (
    .SYS_CLK(clk), .A_RESET_N(rst_n), .bus(bus4));
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [PW-1:0] lfsr_next(logic [PW-1:0] p);
    return {p[PW-2:0], ^(p & POLY)};
  endfunction
  function automatic logic [PW-1:0] rotl(logic [PW-1:0] p, int r);
    logic [PW-1:0] v = p;
    for (int s = 0; s < r % PW; s++) v = {v[PW-2:0], v[PW-1]};
    return v;
  endfunction
  function automatic logic [NCH-1:0] exp_gate();
    logic [NCH-1:0] g = '0;
    for (int i = 0; i < NCH; i++) g[i] = m_st[i] != 0;
    return g;
  endfunction
  task automatic model_reset();
    m_sync = 0;
    m_prng = PW'(1);
    m_cz = 0;
    m_cz4 = 0;
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = 0;
      m_cf[i] = 0;
    end
  endtask
  task automatic model_edge(bit rising, bit seed0, bit clr);
    bit fire;
    if (m_sync)
      for (int i = 0; i < NCH; i++) begin
        fire = bus.EN && bus.UI[i*PW +: PW] >= rotl(m_prng, i);
        if (rising && m_st[i] != 1) begin
          m_st[i] = fire ? 1 : 0;
          if (fire && m_cf[i] < CFMAX) m_cf[i]++;
        end else if (!rising && m_st[i] == 1) m_st[i] = 2;
      end
    m_sync = 1;
    if (m_cz < CFMAX) m_cz++;
    if (m_cz4 < 15) m_cz4++;
    m_prng = seed0 ? PW'(1) : lfsr_next(m_prng);
    if (clr) begin
      m_cz = 0;
      m_cz4 = 0;
      for (int i = 0; i < NCH; i++) m_cf[i] = 0;
    end
  endtask
  task automatic check_counts(string tag);
    check({tag, "_cz"}, 64'(bus.COUNT_ZERO), 64'(m_cz));
    check({tag, "_cz4"}, 64'(bus4.COUNT_ZERO), 64'(m_cz4));
    for (int i = 0; i < NCH; i++)
      check($sformatf("%s_cf%0d", tag, i), 64'(bus.COUNT_FIRE[i*CW +: CW]), 64'(m_cf[i]));
  endtask
  task automatic set_all_ui(logic [PW-1:0] v);
    for (int i = 0; i < NCH; i++) bus.UI[i*PW +: PW] = v;
  endtask
  task automatic do_half(bit lvl, bit seed0 = 1'b0, bit clr = 1'b0);
    logic [NCH-1:0] g_old;
    int k, len;
    g_old = exp_gate();
    len = $urandom_range(8, 16);
    @(negedge clk);
    bus.ZC_IN = lvl;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.ZC_PULSE && k < 20);
    check("zc_latency", 64'(k), 64'(ZF + 3));
    check("half_pol", 64'(bus.HALF_POL), 64'(lvl));
    check("gate_hold", 64'(bus.GATE), 64'(g_old));
    if (seed0) begin
      bus.SEED = '0;
      bus.SEED_LOAD = 1'b1;
    end
    if (clr) bus.CLR_STATS = 1'b1;
    model_edge(lvl, seed0, clr);
    @(negedge clk);
    bus.SEED_LOAD = 1'b0;
    bus.CLR_STATS = 1'b0;
    check("pulse_width", 64'(bus.ZC_PULSE), 64'(0));
    check("gate", 64'(bus.GATE), 64'(exp_gate()));
    check("prng", 64'(bus.PRNG), 64'(m_prng));
    for (int j = k + 1; j < len; j++) @(negedge clk);
  endtask
  task automatic bounce();
    int pulses = 0;
    logic pol0 = bus.HALF_POL;
    @(negedge clk);
    bus.ZC_IN = ~pol0;
    @(negedge clk);
    @(negedge clk);
    bus.ZC_IN = pol0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (bus.ZC_PULSE) pulses++;
    end
    check("bounce_pulse", 64'(pulses), 64'(0));
    check("bounce_pol", 64'(bus.HALF_POL), 64'(pol0));
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.EN = 1'b0;
    bus.SEED = '0;
    bus.SEED_LOAD = 1'b0;
    bus.UI = '0;
    bus.ZC_IN = 1'b0;
    bus.CLR_STATS = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_gate", 64'(bus.GATE), 64'(0));
    check("rst_prng", 64'(bus.PRNG), 64'(1));
    check("rst_pol", 64'(bus.HALF_POL), 64'(0));
    check("rst_pulse", 64'(bus.ZC_PULSE), 64'(0));
    check_counts("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bounce();
    bus.EN = 1'b1;
    bus.UI = {PW'($urandom), PW'(8'h40), PW'(8'hFF), PW'(8'h00)};
    do_half(1'b1);
    check("first_edge_no_fire", 64'(bus.GATE), 64'(0));
    for (int n = 0; n < 100; n++) begin
      do_half(1'b0);
      do_half(1'b1);
    end
    check_counts("duty");
    check("duty_ui0", 64'(bus.COUNT_FIRE[0 +: CW]), 64'(0));
    check("duty_uiff", 64'(bus.COUNT_FIRE[CW +: CW]), 64'(100));
    check("duty_cz", 64'(bus.COUNT_ZERO), 64'(201));
    check("sat_cz4", 64'(bus4.COUNT_ZERO), 64'(15));
    bus.CLR_STATS = 1'b1;
    @(negedge clk);
    bus.CLR_STATS = 1'b0;
    bus.SEED = 8'h5A;
    bus.SEED_LOAD = 1'b1;
    @(negedge clk);
    bus.SEED_LOAD = 1'b0;
    m_cz = 0;
    m_cz4 = 0;
    for (int i = 0; i < NCH; i++) m_cf[i] = 0;
    m_prng = 8'h5A;
    check("seed_load", 64'(bus.PRNG), 64'(8'h5A));
    check_counts("clr");
    set_all_ui(8'd128);
    for (int n = 0; n < 255; n++) begin
      do_half(1'b0);
      do_half(1'b1);
    end
    check_counts("mid");
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NCH; i++) begin
        int r = $urandom_range(0, 3);
        bus.UI[i*PW +: PW] = r == 0 ? PW'(0) : r == 1 ? '1 : PW'($urandom);
      end
      bus.EN = $urandom_range(0, 4) != 0;
      do_half(1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      do_half(1'b1, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      if (n % 10 == 9) check_counts("rand");
    end
    bus.EN = 1'b1;
    do_half(1'b0);
    old_prng = m_prng;
    set_all_ui(8'h00);
    bus.UI[0 +: PW] = old_prng - 1'b1;
    bus.UI[PW +: PW] = rotl(old_prng, 1);
    do_half(1'b1, 1'b1, 1'b0);
    check("seed0_collide", 64'(bus.PRNG), 64'(1));
    check("equal_fires", 64'(bus.GATE[1]), 64'(1));
    if (old_prng > 1) check("old_prng_used", 64'(bus.GATE[0]), 64'(0));
    set_all_ui('1);
    do_half(1'b0);
    do_half(1'b1, 1'b0, 1'b1);
    check("clr_collide_cz", 64'(bus.COUNT_ZERO), 64'(0));
    check("clr_collide_cf", 64'(bus.COUNT_FIRE[0 +: CW]), 64'(0));
    check_counts("clr_collide");
    do_half(1'b0);
    do_half(1'b1);
    check("en_fire_pos", 64'(bus.GATE), 64'(4'hF));
    bus.EN = 1'b0;
    do_half(1'b0);
    check("en_drop_neg", 64'(bus.GATE), 64'(4'hF));
    do_half(1'b1);
    check("en_drop_off", 64'(bus.GATE), 64'(0));
    do_half(1'b0);
    do_half(1'b1);
    check("en_drop_stay", 64'(bus.GATE), 64'(0));
    bus.EN = 1'b1;
    do_half(1'b0);
    do_half(1'b1);
    do_half(1'b0);
    check("pre_reset_gate", 64'(bus.GATE), 64'(4'hF));
    #2 rst_n = 1'b0;
    #1 check("async_reset_gate", 64'(bus.GATE), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("post_reset_prng", 64'(bus.PRNG), 64'(1));
    check_counts("post_reset");
    do_half(1'b1);
    check("post_reset_first", 64'(bus.GATE), 64'(0));
    do_half(1'b0);
    do_half(1'b1);
    check("post_reset_fire", 64'(bus.GATE), 64'(4'hF));
    check_counts("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ac_burst_fire_ctrl.md
# ac_burst_fire_ctrl

Multi-channel, parametrised successor of the single-channel zero-cross motor controller. It takes a raw zero-cross comparator level and filters it, then steps a maximal-length LFSR once per half-cycle. At each positive-going zero-cross, each channel decides whether to fire for a full mains cycle, firing when its duty word `UI` is at least its view of the PRNG. Full-cycle firing keeps the load free of DC. The block replaces the top-level drive/count logic and sits between the user-setting registers and the triac gate drivers.

## Interface
- `NCH`, 4: number of load channels (1..8).
- `PW`, 8: PRNG/duty width (4..16).
- `CW`, 21: statistics counter width.
- `ZC_FILT`, 3: consecutive stable cycles required to accept a zero-cross level change (≥1).
---
- `SYS_CLK`  in  1  system clock.
- `A_RESET_N`  in  1  reset. One clock; reset is asynchronous and active-low.
- `EN`  in  1  enables new firing decisions.
- `SEED`  in  PW  LFSR seed.
- `SEED_LOAD`  in  1  synchronous seed load strobe.
- `UI`  in  NCH*PW  per-channel duty words; channel i at `[i*PW +: PW]`.
- `ZC_IN`  in  1  raw comparator level; 1 = positive half-cycle; asynchronous.
- `CLR_STATS`  in  1  synchronous clear of all counters.
- `HALF_POL`  out  1  filtered half-cycle polarity.
- `ZC_PULSE`  out  1  one-cycle strobe per accepted zero-cross (both edges).
- `PRNG`  out  PW  current LFSR state.
- `GATE`  out  NCH  per-channel gate drive.
- `COUNT_ZERO`  out  CW  accepted zero-crosses.
- `COUNT_FIRE`  out  NCH*CW  per-channel fired full cycles.

## Operation
- **Reset values:**
  - `HALF_POL`=0, `ZC_PULSE`=0, `GATE`=0 and all counters 0.
  - `PRNG`=1.
  - Global FSM = `SYNC_WAIT`.
  - All channel FSMs = `IDLE`.
- **Zero-cross filter:**
  - `ZC_IN` passes through a 2-flop synchroniser.
  - The filtered level takes the new value once the synchronised value has differed from it for `ZC_FILT` consecutive cycles.
  - A differing run that breaks restarts the count.
- **Global FSM:**
  - `SYNC_WAIT` goes to `POS` or `NEG` on the first accepted edge after reset. That first edge produces `ZC_PULSE` but fires no channel.
  - `POS` goes to `NEG` on a falling edge; `NEG` goes to `POS` on a rising edge.
- **LFSR:**
  - Fibonacci, maximal-length, taps per `PW` from the package.
  - Advances on every `ZC_PULSE`.
  - A `SEED_LOAD` with `SEED`=0 loads 1. `SEED_LOAD` has priority over an advance in the same cycle.
- **Channel view of the PRNG:** channel i compares against `PRNG` rotated left by i bits.
- **Channel FSM:**
  - `IDLE` goes to `FIRE_POS` on a rising `ZC_PULSE` when `EN`=1 and `UI_i` ≥ the channel's PRNG view. The decision uses the PRNG value present during the pulse.
  - `FIRE_POS` goes to `FIRE_NEG` on a falling pulse.
  - `FIRE_NEG` goes to `FIRE_POS` on a rising pulse if the decision fires again, otherwise to `IDLE`.
  - `GATE_i` = 1 in `FIRE_POS`/`FIRE_NEG`.
- **Boundary duty values:**
  - `UI`=0 never fires, since the LFSR is never 0.
  - `UI`=all-ones fires every cycle.
- **EN deassertion:** blocks only new decisions. A channel in `FIRE_POS` always completes `FIRE_NEG`, so no half-cycles are orphaned.
- **Counters:**
  - `COUNT_ZERO` increments on every `ZC_PULSE`.
  - `COUNT_FIRE_i` increments on each `IDLE`/`FIRE_NEG` → `FIRE_POS` transition.
  - Both saturate at all-ones.
  - `CLR_STATS` wins over a simultaneous increment, so the result is 0.
- **Reset mid-fire:** `GATE` drops to 0 asynchronously; the state restarts at `SYNC_WAIT`.

## Timing
- Raw `ZC_IN` edge (stable) to `HALF_POL` change: `ZC_FILT`+2 rising edges.
- `ZC_PULSE` is high in the cycle after `HALF_POL` changes.
- `GATE`, `PRNG` and the counters update on the edge that samples `ZC_PULSE` high.
- Total latency from the raw edge to `GATE`: exactly `ZC_FILT`+4 edges.
- No combinational path from any input to any output. All outputs are registered.

## Structure
- **Package `ac_ctrl_pkg`:**
  - LFSR tap constant function indexed by `PW` (4..16).
  - Global state enum {`SYNC_WAIT`, `POS`, `NEG`}.
  - Channel state enum {`IDLE`, `FIRE_POS`, `FIRE_NEG`}.
  - Elaboration assertions on the parameter ranges.
- **Sub-module `zc_filter`:** synchroniser plus stability counter plus edge strobe. It outputs `HALF_POL` and `ZC_PULSE`.
- **Channel logic:** a generate loop over `NCH` in the top-level.

## Test plan
- **Bounce rejection:** `ZC_FILT`=3, `ZC_IN` glitch 2 cycles wide → no `ZC_PULSE`. Clean edge → `GATE` changes at edge+7.
- **Duty limits:** `UI0`=0, `UI1`=all-ones, `EN`=1, 100 mains cycles → `COUNT_FIRE0`=0, `COUNT_FIRE1`=100, `COUNT_ZERO`=201 (first edge included).
- **Mid-duty statistics:** `PW`=8, `UI`=128, seed 0x5A, 255 full cycles → `COUNT_FIRE` matches the reference-model LFSR count exactly. Every fire spans exactly one positive and one negative half.
- **EN dropped:** `EN` driven to 0 while a channel is in `FIRE_POS` → `GATE` stays 1 through the following negative half, then 0 and stays 0.
- **Same-cycle collisions:**
  - `SEED_LOAD` with `SEED`=0 coincident with `ZC_PULSE` → `PRNG`=1 next cycle; the decision uses the old PRNG.
  - `CLR_STATS` coincident with an increment → counter 0.
- **Saturation and reset:**
  - `CW`=4, 20 edges → `COUNT_ZERO`=15.
  - `A_RESET_N` low mid-fire → `GATE`=0 within the same cycle; the first post-reset edge does not fire.
